// File: rtl/vram_line_sched.sv
// Shared video SRAM sequencer: bursts one scanline into a line buffer half on
// line_start and serves single CPU reads/writes between bursts.
module vram_line_sched #(
  parameter int WORDS_PER_LINE = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [17:0] line_base,
  input  logic        line_sel,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        overrun,
  output logic [8:0]  lbw_adr,
  output logic [31:0] lbw_dat,
  output logic        lbw_we,
  output logic [17:0] v_adr,
  input  logic [15:0] v_dat_i,
  output logic [15:0] v_dat_o,
  output logic        v_oe_sram,
  output logic        v_we,
  output logic        v_oe_pin,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_adr,
  input  logic [15:0] cpu_dat_i,
  output logic [15:0] cpu_dat_o,
  output logic        cpu_ack
);

  localparam logic [9:0] ISSUES     = 10'(2 * WORDS_PER_LINE);
  localparam logic [7:0] LAST_ENTRY = 8'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_CPU_RD, S_CPU_RDACK, S_CPU_WR, S_CPU_WRACK
  } state_e;

  state_e      state_q;
  logic        pending_q, pend_sel_q, sel_q;
  logic [17:0] pend_base_q;
  logic        fetch_busy_q, fetch_done_q;
  logic [8:0]  lbw_adr_q;
  logic [31:0] lbw_dat_q;
  logic        lbw_we_q;
  logic [15:0] lo_q;
  logic [7:0]  entry_q;
  logic [9:0]  iss_cnt_q;
  logic        iss_vld_q, iss_odd_q, d1_vld_q, d1_odd_q;
  logic [17:0] v_adr_q;
  logic [15:0] v_dat_o_q, cpu_dat_q;
  logic        v_oe_q, v_we_q, cpu_ack_q;

  logic        drain_done, dispatch, go_fetch, fetch_sel;
  logic [17:0] fetch_base;

  // Finishing DRAIN arbitrates exactly like IDLE so the next user starts at once.
  assign drain_done = (state_q == S_DRAIN) && lbw_we_q && (lbw_adr_q[7:0] == LAST_ENTRY);
  assign dispatch   = (state_q == S_IDLE) || drain_done;
  assign go_fetch   = line_start || pending_q;
  assign fetch_base = pending_q ? pend_base_q : line_base;
  assign fetch_sel  = pending_q ? pend_sel_q : line_sel;
  assign overrun    = line_start && pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_base_q <= '0;
    end else if (dispatch && go_fetch) begin
      pending_q <= 1'b0;
    end else if (line_start && !pending_q) begin
      pending_q   <= 1'b1;
      pend_base_q <= line_base;
      pend_sel_q  <= line_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      fetch_busy_q <= 1'b0;
      fetch_done_q <= 1'b0;
      lbw_adr_q    <= '0;
      lbw_dat_q    <= '0;
      lbw_we_q     <= 1'b0;
      lo_q         <= '0;
      entry_q      <= '0;
      iss_cnt_q    <= '0;
      iss_vld_q    <= 1'b0;
      iss_odd_q    <= 1'b0;
      d1_vld_q     <= 1'b0;
      d1_odd_q     <= 1'b0;
      v_adr_q      <= '0;
      v_dat_o_q    <= '0;
      v_oe_q       <= 1'b0;
      v_we_q       <= 1'b0;
      cpu_dat_q    <= '0;
      cpu_ack_q    <= 1'b0;
    end else begin
      lbw_we_q     <= 1'b0;
      fetch_done_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      iss_vld_q    <= 1'b0;
      // Issue tag travels two stages: address out, then data on v_dat_i.
      d1_vld_q     <= iss_vld_q;
      d1_odd_q     <= iss_odd_q;

      if (d1_vld_q) begin
        if (!d1_odd_q) begin
          lo_q <= v_dat_i;
        end else begin
          lbw_dat_q <= {v_dat_i, lo_q};
          lbw_adr_q <= {sel_q, entry_q};
          lbw_we_q  <= 1'b1;
          entry_q   <= entry_q + 8'd1;
        end
      end

      if (drain_done) begin
        fetch_done_q <= 1'b1;
        fetch_busy_q <= 1'b0;
      end

      if (dispatch) begin
        if (go_fetch) begin
          state_q      <= S_FETCH;
          fetch_busy_q <= 1'b1;
          sel_q        <= fetch_sel;
          entry_q      <= '0;
          v_adr_q      <= fetch_base;
          v_oe_q       <= 1'b1;
          iss_vld_q    <= 1'b1;
          iss_odd_q    <= 1'b0;
          iss_cnt_q    <= 10'd1;
        end else if (cpu_req) begin
          v_adr_q <= cpu_adr;
          if (cpu_we) begin
            state_q   <= S_CPU_WR;
            v_dat_o_q <= cpu_dat_i;
            v_we_q    <= 1'b1;
          end else begin
            state_q <= S_CPU_RD;
            v_oe_q  <= 1'b1;
          end
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (iss_cnt_q == ISSUES) begin
              v_oe_q  <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              v_adr_q   <= v_adr_q + 18'd1;
              iss_vld_q <= 1'b1;
              iss_odd_q <= iss_cnt_q[0];
              iss_cnt_q <= iss_cnt_q + 10'd1;
            end
          end
          S_DRAIN: state_q <= S_DRAIN;
          S_CPU_RD: begin
            v_oe_q  <= 1'b0;
            state_q <= S_CPU_RDACK;
          end
          S_CPU_RDACK: begin
            cpu_dat_q <= v_dat_i;
            cpu_ack_q <= 1'b1;
            state_q   <= S_IDLE;
          end
          S_CPU_WR: begin
            v_we_q  <= 1'b0;
            state_q <= S_CPU_WRACK;
          end
          S_CPU_WRACK: begin
            cpu_ack_q <= 1'b1;
            state_q   <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fetch_busy = fetch_busy_q;
  assign fetch_done = fetch_done_q;
  assign lbw_adr    = lbw_adr_q;
  assign lbw_dat    = lbw_dat_q;
  assign lbw_we     = lbw_we_q;
  assign v_adr      = v_adr_q;
  assign v_dat_o    = v_dat_o_q;
  assign v_oe_sram  = v_oe_q;
  assign v_we       = v_we_q;
  assign v_oe_pin   = v_we_q;
  assign cpu_dat_o  = cpu_dat_q;
  assign cpu_ack    = cpu_ack_q;

endmodule
